// File: rtl/spdif_rx.sv
// S/PDIF (IEC 60958) biphase-mark receiver.
//
// Oversamples the line with clock_i, measures pulse widths in unit intervals (UI),
// recognises B/M/W preambles and decodes each 32-slot sub-frame into a 24-bit
// sample plus V/U/C/P status. Outputs update, with a one-cycle strobe_o, only
// while locked.
//
// Ports:
//   clock_i       oversampling clock
//   reset_i       asynchronous active-high reset
//   spdif_i       S/PDIF line (asynchronous)
//   sample_o      audio sample, slot 4 = LSB
//   channel_o     0 = channel A (B/M preamble), 1 = channel B (W)
//   valid_o       V bit
//   user_o        U bit
//   cstat_o       C bit
//   parity_err_o  even parity over slots 4..31 failed
//   block_o       sub-frame began with a B preamble
//   strobe_o      one-cycle pulse when the outputs above update
//   lock_o        receiver locked
//   cs_o          channel-A channel-status word, frame 0 at bit 0 (SPDIF_RX_CSTAT_EN)
//   cs_valid_o    pulses with the strobe that completes cs_o (SPDIF_RX_CSTAT_EN)
//
// Optional feature macro: SPDIF_RX_CSTAT_EN adds cs_o/cs_valid_o.
module spdif_rx #(
  parameter int unsigned UI_CYCLES      = 4,
  parameter int unsigned LOCK_SUBFRAMES = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        spdif_i,
  output logic [23:0] sample_o,
  output logic        channel_o,
  output logic        valid_o,
  output logic        user_o,
  output logic        cstat_o,
  output logic        parity_err_o,
  output logic        block_o,
  output logic        strobe_o,
  output logic        lock_o
`ifdef SPDIF_RX_CSTAT_EN
  ,
  output logic [31:0] cs_o,
  output logic        cs_valid_o
`endif
);

  localparam int unsigned CntMax = 4 * UI_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned GoodW  = $clog2(LOCK_SUBFRAMES + 1);
  localparam logic [GoodW-1:0] GoodMax = GoodW'(LOCK_SUBFRAMES);

  typedef enum logic [1:0] {PwOne, PwTwo, PwThree, PwBad} pw_e;
  typedef enum logic [1:0] {PtB, PtM, PtW} pt_e;
  typedef enum logic [1:0] {StHunt, StPre, StData, StEnd} state_e;

  // Input synchroniser and edge detection
  logic sync1_q, sync2_q, level_q, edge_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= spdif_i;
      sync2_q <= sync1_q;
      level_q <= sync2_q;
      edge_q  <= sync2_q ^ level_q;
      if (edge_q) begin
        cnt_q <= '0;
      end else if (cnt_q < CntW'(CntMax)) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  // Pulse length L = cnt_q + 1; compare 2L against odd multiples of UI/2.
  logic [31:0] len2;
  pw_e         pw;
  always_comb begin
    len2 = (32'(cnt_q) << 1) + 32'd2;
    if (len2 < 3 * UI_CYCLES)      pw = PwOne;
    else if (len2 < 5 * UI_CYCLES) pw = PwTwo;
    else if (len2 < 7 * UI_CYCLES) pw = PwThree;
    else                           pw = PwBad;
  end

  state_e      state_q, state_d;
  pw_e         pre1_q, pre1_d, pre2_q, pre2_d;
  logic [1:0]  pre_cnt_q, pre_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        half_q, half_d;
  logic [26:0] shift_q, shift_d;
  logic        first_q, first_d;
  logic        prev_w_q, prev_w_d;
  pt_e         cur_q, cur_d;
  logic [GoodW-1:0] good_q, good_d;
  logic        lock_q, lock_d, strobe_q, strobe_d;
  logic [23:0] sample_q, sample_d;
  logic        chan_q, chan_d, v_q, v_d, u_q, u_d, c_q, c_d, perr_q, perr_d, blk_q, blk_d;

  logic        err, bit_ok, bit_val;
  logic        pre_ok;
  pt_e         pre_type;
  logic [27:0] word;

  always_comb begin
    state_d   = state_q;
    pre1_d    = pre1_q;
    pre2_d    = pre2_q;
    pre_cnt_d = pre_cnt_q;
    bit_cnt_d = bit_cnt_q;
    half_d    = half_q;
    shift_d   = shift_q;
    first_d   = first_q;
    prev_w_d  = prev_w_q;
    cur_d     = cur_q;
    good_d    = good_q;
    lock_d    = lock_q;
    strobe_d  = 1'b0;
    sample_d  = sample_q;
    chan_d    = chan_q;
    v_d       = v_q;
    u_d       = u_q;
    c_d       = c_q;
    perr_d    = perr_q;
    blk_d     = blk_q;
    err       = 1'b0;
    bit_ok    = 1'b0;
    bit_val   = 1'b0;
    word      = {1'b0, shift_q};

    // The first 3UI was consumed on entry to StPre; these are the other three.
    pre_ok   = 1'b1;
    pre_type = PtB;
    if (pre1_q == PwOne && pre2_q == PwOne && pw == PwThree)        pre_type = PtB;
    else if (pre1_q == PwThree && pre2_q == PwOne && pw == PwOne)   pre_type = PtM;
    else if (pre1_q == PwTwo && pre2_q == PwOne && pw == PwTwo)     pre_type = PtW;
    else                                                            pre_ok   = 1'b0;

    if (edge_q) begin
      unique case (state_q)
        StHunt: begin
          if (pw == PwThree) begin
            state_d   = StPre;
            pre_cnt_d = 2'd0;
          end
        end
        StPre: begin
          if (pw == PwBad) begin
            err = 1'b1;
          end else if (pre_cnt_q == 2'd0) begin
            pre1_d    = pw;
            pre_cnt_d = 2'd1;
          end else if (pre_cnt_q == 2'd1) begin
            pre2_d    = pw;
            pre_cnt_d = 2'd2;
          end else if (!pre_ok) begin
            err = 1'b1;
          end else if (!first_q && (prev_w_q == (pre_type == PtW))) begin
            // Channels must alternate A/B once a run is established.
            err = 1'b1;
          end else begin
            state_d   = StData;
            bit_cnt_d = 5'd0;
            half_d    = 1'b0;
            cur_d     = pre_type;
            first_d   = 1'b0;
            prev_w_d  = (pre_type == PtW);
          end
        end
        StData: begin
          if (!half_q) begin
            if (pw == PwTwo) begin
              bit_ok = 1'b1;
            end else if (pw == PwOne) begin
              half_d = 1'b1;
            end else begin
              err = 1'b1;
            end
          end else if (pw == PwOne) begin
            bit_ok  = 1'b1;
            bit_val = 1'b1;
            half_d  = 1'b0;
          end else begin
            err = 1'b1;
          end
        end
        StEnd: begin
          if (pw == PwThree) begin
            state_d   = StPre;
            pre_cnt_d = 2'd0;
          end else begin
            err = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (bit_ok) begin
      shift_d   = {bit_val, shift_q[26:1]};
      bit_cnt_d = bit_cnt_q + 5'd1;
      word      = {bit_val, shift_q};
      // Slot 31 decided: sub-frame complete.
      if (bit_cnt_q == 5'd27) begin
        state_d = StEnd;
        if (good_q != GoodMax) good_d = good_q + GoodW'(1);
        lock_d = (good_d == GoodMax);
        if (lock_d) begin
          strobe_d = 1'b1;
          sample_d = word[23:0];
          v_d      = word[24];
          u_d      = word[25];
          c_d      = word[26];
          perr_d   = ^word;
          chan_d   = (cur_q == PtW);
          blk_d    = (cur_q == PtB);
        end
      end
    end

    if (err) begin
      state_d = StHunt;
      lock_d  = 1'b0;
      good_d  = '0;
      first_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StHunt;
      pre1_q    <= PwOne;
      pre2_q    <= PwOne;
      pre_cnt_q <= 2'd0;
      bit_cnt_q <= 5'd0;
      half_q    <= 1'b0;
      shift_q   <= '0;
      first_q   <= 1'b1;
      prev_w_q  <= 1'b0;
      cur_q     <= PtB;
      good_q    <= '0;
      lock_q    <= 1'b0;
      strobe_q  <= 1'b0;
      sample_q  <= '0;
      chan_q    <= 1'b0;
      v_q       <= 1'b0;
      u_q       <= 1'b0;
      c_q       <= 1'b0;
      perr_q    <= 1'b0;
      blk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre1_q    <= pre1_d;
      pre2_q    <= pre2_d;
      pre_cnt_q <= pre_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      half_q    <= half_d;
      shift_q   <= shift_d;
      first_q   <= first_d;
      prev_w_q  <= prev_w_d;
      cur_q     <= cur_d;
      good_q    <= good_d;
      lock_q    <= lock_d;
      strobe_q  <= strobe_d;
      sample_q  <= sample_d;
      chan_q    <= chan_d;
      v_q       <= v_d;
      u_q       <= u_d;
      c_q       <= c_d;
      perr_q    <= perr_d;
      blk_q     <= blk_d;
    end
  end

  assign sample_o     = sample_q;
  assign channel_o    = chan_q;
  assign valid_o      = v_q;
  assign user_o       = u_q;
  assign cstat_o      = c_q;
  assign parity_err_o = perr_q;
  assign block_o      = blk_q;
  assign strobe_o     = strobe_q;
  assign lock_o       = lock_q;

`ifdef SPDIF_RX_CSTAT_EN
  // Channel-status capture: one C bit per locked channel-A sub-frame, starting at a B.
  logic [31:0] cs_sr_q, cs_sr_d, cs_q, cs_d;
  logic [4:0]  cs_cnt_q, cs_cnt_d;
  logic        cs_arm_q, cs_arm_d, cs_valid_q, cs_valid_d;

  always_comb begin
    cs_sr_d    = cs_sr_q;
    cs_q_hold: begin
    end
    cs_d       = cs_q;
    cs_cnt_d   = cs_cnt_q;
    cs_arm_d   = cs_arm_q;
    cs_valid_d = 1'b0;
    if (err) begin
      cs_arm_d = 1'b0;
    end else if (strobe_d && cur_q != PtW) begin
      if (cur_q == PtB) begin
        cs_sr_d[0] = word[26];
        cs_cnt_d   = 5'd1;
        cs_arm_d   = 1'b1;
      end else if (cs_arm_q) begin
        cs_sr_d[cs_cnt_q] = word[26];
        cs_cnt_d          = cs_cnt_q + 5'd1;
        if (cs_cnt_q == 5'd31) begin
          cs_d       = cs_sr_d;
          cs_valid_d = 1'b1;
          cs_arm_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cs_sr_q    <= '0;
      cs_q       <= '0;
      cs_cnt_q   <= 5'd0;
      cs_arm_q   <= 1'b0;
      cs_valid_q <= 1'b0;
    end else begin
      cs_sr_q    <= cs_sr_d;
      cs_q       <= cs_d;
      cs_cnt_q   <= cs_cnt_d;
      cs_arm_q   <= cs_arm_d;
      cs_valid_q <= cs_valid_d;
    end
  end

  assign cs_o       = cs_q;
  assign cs_valid_o = cs_valid_q;
`endif

endmodule

// File: tb/tb_spdif_rx.sv
// Directed, table-driven bench for spdif_rx: each table row is one sub-frame with
// its expected strobe/lock outcome; hand sequences cover reset and errors mid-frame.
module tb_spdif_rx;

  localparam int UI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sdi;
  logic [23:0] sample;
  logic        channel, valid, user, cstat, perr, block, strobe, lock;
`ifdef SPDIF_RX_CSTAT_EN
  logic [31:0] cs;
  logic        cs_valid;
`endif

  always #5 clk = ~clk;

  spdif_rx #(
    .UI_CYCLES      (UI),
    .LOCK_SUBFRAMES (4)
  ) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .spdif_i      (sdi),
    .sample_o     (sample),
    .channel_o    (channel),
    .valid_o      (valid),
    .user_o       (user),
    .cstat_o      (cstat),
    .parity_err_o (perr),
    .block_o      (block),
    .strobe_o     (strobe),
    .lock_o       (lock)
`ifdef SPDIF_RX_CSTAT_EN
    ,
    .cs_o         (cs),
    .cs_valid_o   (cs_valid)
`endif
  );

  typedef struct {
    logic [1:0]  pt;     // 0 = B, 1 = M, 2 = W
    logic [23:0] smp;
    logic        v, u, c;
    logic        pflip;  // transmit wrong parity
    int          bad_at; // insert a 14-cycle pulse before this data bit (-1 = none)
    int          rst_at; // pulse reset before this data bit (-1 = none)
    logic        ex_strobe;
    logic        ex_lock;
  } vec_t;

  vec_t vecs[24];

  int total = 0;
  int bad   = 0;
  int n_strobe = 0;
  int exp_strobes = 0;
  logic last_lock = 1'b0;

  logic [23:0] h_smp;
  logic        h_ch, h_blk, h_v, h_u, h_c, h_pe;

`ifdef SPDIF_RX_CSTAT_EN
  int          n_csv = 0;
  logic [31:0] cs_seen = '0;
  logic        csv_with_strobe = 1'b0;
  always @(negedge clk) if (cs_valid === 1'b1) begin
    n_csv++;
    cs_seen = cs;
    csv_with_strobe = strobe;
  end
`endif

  always @(negedge clk) if (strobe === 1'b1) n_strobe++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] pt, input logic [23:0] smp, input logic v,
                              input logic u, input logic c, input logic pflip, input int bad_at,
                              input int rst_at, input logic ex_strobe, input logic ex_lock);
    vec_t r;
    r.pt = pt; r.smp = smp; r.v = v; r.u = u; r.c = c; r.pflip = pflip;
    r.bad_at = bad_at; r.rst_at = rst_at; r.ex_strobe = ex_strobe; r.ex_lock = ex_lock;
    return r;
  endfunction

  // Toggle the line, then hold for the given number of cycles.
  task automatic pulse(input int cycles);
    sdi = ~sdi;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_sample"}, 32'(sample), 32'h0);
    check({nm, "_flags"}, 32'({channel, valid, user, cstat, perr, block}), 32'h0);
    check({nm, "_strobe"}, 32'(strobe), 32'h0);
    check({nm, "_lock"}, 32'(lock), 32'h0);
`ifdef SPDIF_RX_CSTAT_EN
    check({nm, "_cs"}, cs, 32'h0);
    check({nm, "_csv"}, 32'(cs_valid), 32'h0);
`endif
  endtask

  // Remainder of the preamble (its first 3UI was sent by close_check) plus data slots.
  task automatic send_rest(input vec_t r);
    logic [27:0] w;
    logic        p;
    p = (^{r.c, r.u, r.v, r.smp}) ^ r.pflip;
    w = {p, r.c, r.u, r.v, r.smp};
    case (r.pt)
      2'd0:    begin pulse(UI);     pulse(UI); pulse(3 * UI); end
      2'd1:    begin pulse(3 * UI); pulse(UI); pulse(UI);     end
      default: begin pulse(2 * UI); pulse(UI); pulse(2 * UI); end
    endcase
    for (int i = 0; i < 28; i++) begin
      if (i == r.rst_at) begin
        #3 rst = 1'b1;
        #1 check_all_zero("mid_reset");
        #3 rst = 1'b0;
        @(negedge clk);
        h_smp = '0; {h_ch, h_blk, h_v, h_u, h_c, h_pe} = '0;
        last_lock = 1'b0;
      end
      if (i == r.bad_at) begin
        pulse(14);
        sdi = ~sdi;
        repeat (3) @(negedge clk);
        check("lock_before_bad_edge", 32'(lock), 32'(last_lock));
        @(negedge clk);
        check("lock_drop", 32'(lock), 32'h0);
        check("bad_sample_hold", 32'(sample), 32'(h_smp));
        repeat (4) @(negedge clk);
        last_lock = 1'b0;
      end
      if (w[i]) begin
        pulse(UI);
        pulse(UI);
      end else begin
        pulse(2 * UI);
      end
    end
  endtask

  // Closing edge of slot 31 (start of the next 3UI preamble pulse) and its checks.
  task automatic close_check(input vec_t r);
    sdi = ~sdi;
    repeat (3) @(negedge clk);
    check("strobe_early", 32'(strobe), 32'h0);
    @(negedge clk);
    check("strobe", 32'(strobe), 32'(r.ex_strobe));
    check("lock", 32'(lock), 32'(r.ex_lock));
    if (r.ex_strobe) begin
      exp_strobes++;
      h_smp = r.smp;
      h_ch  = (r.pt == 2'd2);
      h_blk = (r.pt == 2'd0);
      h_v   = r.v;
      h_u   = r.u;
      h_c   = r.c;
      h_pe  = r.pflip;
    end
    check("sample", 32'(sample), 32'(h_smp));
    check("channel", 32'(channel), 32'(h_ch));
    check("block", 32'(block), 32'(h_blk));
    check("vuc", 32'({valid, user, cstat}), 32'({h_v, h_u, h_c}));
    check("parity_err", 32'(perr), 32'(h_pe));
    @(negedge clk);
    check("strobe_width", 32'(strobe), 32'h0);
    repeat (3 * UI - 5) @(negedge clk);
    last_lock = r.ex_lock;
  endtask

  initial begin
    //             pt     sample       v     u     c     flip  bad rst  stb   lock
    vecs[0]  = mk(2'd0, 24'h123456, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    vecs[1]  = mk(2'd2, 24'hABCDEF, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    vecs[2]  = mk(2'd1, 24'h123456, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    vecs[3]  = mk(2'd2, 24'hABCDEF, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1, 1'b1);
    vecs[4]  = mk(2'd0, 24'h123456, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1, 1'b1);
    vecs[5]  = mk(2'd2, 24'hABCDEF, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1, 1'b1, 1'b1);
    vecs[6]  = mk(2'd1, 24'h000001, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1, 1'b1);
    vecs[7]  = mk(2'd2, 24'h800000, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1, 1'b1, 1'b1);
    vecs[8]  = mk(2'd1, 24'h5A5A5A, 1'b0, 1'b1, 1'b0, 1'b0, 10, -1, 1'b0, 1'b0);
    vecs[9]  = mk(2'd2, 24'h111111, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    vecs[10] = mk(2'd1, 24'h222222, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    vecs[11] = mk(2'd2, 24'h333333, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    vecs[12] = mk(2'd1, 24'h444444, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1, 1'b1);
    vecs[13] = mk(2'd1, 24'h555555, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    vecs[14] = mk(2'd2, 24'h666666, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    vecs[15] = mk(2'd0, 24'h777777, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    vecs[16] = mk(2'd2, 24'h888888, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    vecs[17] = mk(2'd0, 24'h999999, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1, 1'b1);
    vecs[18] = mk(2'd2, 24'hAAAAAA, 1'b0, 1'b1, 1'b0, 1'b0, -1,  5, 1'b0, 1'b0);
    vecs[19] = mk(2'd0, 24'h0F0F0F, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    vecs[20] = mk(2'd2, 24'hF0F0F0, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    vecs[21] = mk(2'd1, 24'h13579B, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    vecs[22] = mk(2'd2, 24'h2468AC, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1, 1'b1);
    vecs[23] = mk(2'd0, 24'hFEDCBA, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1, 1'b1, 1'b1);

    h_smp = '0;
    {h_ch, h_blk, h_v, h_u, h_c, h_pe} = '0;
    sdi = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_lock", 32'(lock), 32'h0);

    // First 3UI of the first preamble.
    pulse(3 * UI);
    for (int i = 0; i < 24; i++) begin
      send_rest(vecs[i]);
      close_check(vecs[i]);
    end

`ifdef SPDIF_RX_CSTAT_EN
    begin
      logic [31:0] cword;
      vec_t        r;
      cword = 32'h0200_0004;
      r = mk(2'd2, 24'h0000AA, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 1'b1, 1'b1);
      send_rest(r);
      close_check(r);
      for (int f = 0; f < 32; f++) begin
        r = mk((f == 0) ? 2'd0 : 2'd1, 24'(f), 1'b0, 1'b0, cword[f], 1'b0, -1, -1, 1'b1, 1'b1);
        send_rest(r);
        close_check(r);
        r = mk(2'd2, 24'(f + 100), 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 1'b1, 1'b1);
        send_rest(r);
        close_check(r);
      end
      check("cs_valid_count", 32'(n_csv), 32'd1);
      check("cs_word", cs_seen, cword);
      check("cs_valid_with_strobe", 32'(csv_with_strobe), 32'h1);
    end
`endif

    repeat (10) @(negedge clk);
    check("strobe_count", 32'(n_strobe), 32'(exp_strobes));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spdif_rx.md
Name: spdif_rx

Overview:
- S/PDIF (IEC 60958) receiver; the counterpart of the team's S/PDIF transmitter.
- Oversamples the biphase-mark line with clock_i, measures pulse widths and detects B/M/W preambles.
- Decodes 32-slot sub-frames into a 24-bit sample plus V/U/C/P bits and lock/error status for downstream audio logic.

Parameters:
- UI_CYCLES, 4: clock_i cycles per biphase unit interval (UI = half a data bit). 24.576 MHz clock at 48 kHz gives 4.
- LOCK_SUBFRAMES, 4: consecutive error-free sub-frames needed to assert lock_o.

Ports:
- clock_i  in  1  system/oversampling clock.
- reset_i  in  1  asynchronous, active-high reset.
- spdif_i  in  1  S/PDIF line, asynchronous to clock_i.
- sample_o  out  24  audio sample (slots 4..27, slot 4 = LSB).
- channel_o  out  1  0 = channel A (B/M preamble), 1 = channel B (W).
- valid_o  out  1  V bit (slot 28).
- user_o  out  1  U bit (slot 29).
- cstat_o  out  1  C bit (slot 30).
- parity_err_o  out  1  even parity over slots 4..31 failed.
- block_o  out  1  current sub-frame began with a B preamble.
- strobe_o  out  1  one-cycle pulse; all sub-frame outputs updated.
- lock_o  out  1  receiver locked.

Behaviour:
- Reset: all outputs 0. State HUNT, counters 0. Applies immediately, including mid-sub-frame.
- Input path: spdif_i passes 2 sync flops, then an edge register. An edge is any change of the synced level.
- Pulse measurement:
  - Counter clears on each edge and saturates at 4*UI_CYCLES.
  - The width L is classified at the edge:
    - 1UI: L < 1.5*UI_CYCLES.
    - 2UI: L < 2.5*UI_CYCLES.
    - 3UI: L < 3.5*UI_CYCLES.
    - Otherwise BAD. With UI_CYCLES=4: 1..5, 6..9, 10..13, >=14.
- Preamble width sequences (polarity-independent):
  - B = 3,1,1,3.
  - M = 3,3,1,1.
  - W = 3,2,1,2.
- State machine:
  - HUNT: wait for a 3UI pulse, then PRE.
  - PRE: collect 3 more widths. A match goes to DATA with a bit counter of 0. A mismatch or BAD is an error.
  - DATA: decode 28 bits (slots 4..31).
    - Bit 0 = one 2UI pulse.
    - Bit 1 = two 1UI pulses.
    - A 1UI followed by a 2UI or 3UI is an error.
    - A 3UI or BAD before 28 bits is an error.
  - After slot 31: the sub-frame is complete. The next pulse must be 3UI, which enters PRE; any other pulse is an error.
- Sequence check: after B or M, a W is required; after W, B or M is required. A violation is an error. The first sub-frame after HUNT is exempt.
- Error handling:
  - Return to HUNT, clear lock_o and the good-sub-frame counter.
  - Hold sample and status outputs.
- Lock: lock_o rises on the sub-frame completion that makes the good count reach LOCK_SUBFRAMES. A parity error does not break lock.
- Completion:
  - The bit decision for slot 31 occurs on the edge ending it (the first edge of the next preamble).
  - When lock_o is (or becomes) 1, register the outputs and pulse strobe_o for one cycle. This is exactly 4 clock_i cycles after that spdif_i transition.
  - While unlocked, outputs are not updated and there is no strobe.
- parity_err_o and block_o are valid with strobe_o and held until the next strobe.

Optional Feature:
- Macro: SPDIF_RX_CSTAT_EN.
- When defined:
  - Adds outputs cs_o[31:0] and cs_valid_o.
  - Shifts channel-A C bits into a register, with bit 0 = frame 0 (the B sub-frame).
  - After frame 31, latches cs_o and pulses cs_valid_o together with that sub-frame's strobe_o.
  - A lock loss mid-block discards the partial word; capture restarts at the next B.
  - cs_o and cs_valid_o reset to 0.
- When undefined: these ports and the logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-sub-frame with spdif_i toggling -> all outputs 0 next cycle; lock_o rises only after 4 new good sub-frames.
- Stream B(0x123456), W(0xABCDEF), M, W..., V=0, U=1, C=0, correct parity -> lock_o at the 4th completion. Strobes carry 0x123456/ch0/block_o=1, then 0xABCDEF/ch1/block_o=0, user_o=1, each 4 cycles after the closing edge.
- Locked stream, flip parity bit on one W sub-frame -> that strobe has parity_err_o=1 with the correct sample; lock_o stays 1; next strobe parity_err_o=0.
- Insert a 14-cycle pulse mid-DATA -> lock_o falls within 1 cycle of the edge, no strobe; outputs hold; relock after 4 good sub-frames.
- Send M then M (missing W) -> error: lock_o=0, no strobe for the second M.
- SPDIF_RX_CSTAT_EN defined: one block with channel-A C bits 0x02000004 in frames 0..31 -> cs_o=0x02000004, cs_valid_o pulses once at frame 31's strobe.
